// File: rtl/rf_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_channel_arbiter
//  Description : Round-robin arbiter sharing one min/max range finder among
//                NCH sample streams; emits range, count and channel per burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_channel_arbiter #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 4,
  parameter int CWIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*WIDTH-1:0]     req_data,
  input  logic [NCH-1:0]           req_last,
  output logic [NCH-1:0]           req_ready,
  output logic [NCH-1:0]           grant,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_range,
  output logic [$clog2(NCH)-1:0]   res_chan,
  output logic [CWIDTH-1:0]        res_count,
  output logic                     busy
);

  localparam int CHW = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CHW-1:0]      r_rr_ptr;
  logic [CHW-1:0]      r_owner;
  logic [NCH-1:0]      r_grant;
  logic [WIDTH-1:0]    r_min;
  logic [WIDTH-1:0]    r_max;
  logic [CWIDTH-1:0]   r_count;
  logic                r_res_valid;
  logic [WIDTH-1:0]    r_res_range;
  logic [CHW-1:0]      r_res_chan;
  logic [CWIDTH-1:0]   r_res_count;

  logic                w_found;
  logic [CHW-1:0]      w_winner;
  logic [CHW:0]        w_idx;
  logic [CHW:0]        w_ptr_sum;
  logic [CHW-1:0]      w_ptr_nxt;
  logic [NCH-1:0]      w_win_oh;
  logic [WIDTH-1:0]    w_own_data;
  logic                w_own_last;
  logic                w_accept;
  logic                w_done;
  logic [WIDTH-1:0]    w_new_min;
  logic [WIDTH-1:0]    w_new_max;
  logic [CWIDTH-1:0]   w_new_count;

  // Search upward from the round-robin pointer, wrapping past NCH-1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (CHW+1)'(k);
      if (w_idx >= (CHW+1)'(NCH)) w_idx = w_idx - (CHW+1)'(NCH);
      if (!w_found && req_valid[w_idx[CHW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[CHW-1:0];
      end
    end
  end

  always_comb begin
    w_ptr_sum = {1'b0, w_winner} + (CHW+1)'(1);
    if (w_ptr_sum == (CHW+1)'(NCH)) w_ptr_sum = '0;
    w_ptr_nxt = w_ptr_sum[CHW-1:0];
    w_win_oh  = {{(NCH-1){1'b0}}, 1'b1} << w_winner;
  end

  always_comb begin
    w_own_data = '0;
    w_own_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_owner == CHW'(i)) begin
        w_own_data = req_data[i*WIDTH +: WIDTH];
        w_own_last = req_last[i];
      end
    end
  end

  assign w_accept = (r_state == S_COLLECT) && |(req_valid & r_grant);
  assign w_done   = w_accept && w_own_last;

  // A zero count marks the first sample: counts never wrap back to zero.
  always_comb begin
    if (r_count == '0) begin
      w_new_min   = w_own_data;
      w_new_max   = w_own_data;
      w_new_count = CWIDTH'(1);
    end else begin
      w_new_min   = (w_own_data < r_min) ? w_own_data : r_min;
      w_new_max   = (w_own_data > r_max) ? w_own_data : r_max;
      w_new_count = (&r_count) ? r_count : r_count + CWIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found)   w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_done)    w_state_nxt = S_RESULT;
      S_RESULT:  if (res_ready) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_range <= '0;
      r_res_chan  <= '0;
      r_res_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= w_win_oh;
            r_owner  <= w_winner;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        S_COLLECT: begin
          if (w_done) begin
            r_res_range <= w_new_max - w_new_min;
            r_res_chan  <= r_owner;
            r_res_count <= w_new_count;
            r_res_valid <= 1'b1;
            r_grant     <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_count     <= '0;
          end else if (w_accept) begin
            r_min   <= w_new_min;
            r_max   <= w_new_max;
            r_count <= w_new_count;
          end
        end
        S_RESULT: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign req_ready = (r_state == S_COLLECT) ? r_grant : '0;
  assign grant     = r_grant;
  assign res_valid = r_res_valid;
  assign res_range = r_res_range;
  assign res_chan  = r_res_chan;
  assign res_count = r_res_count;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
